// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states
// and the byte width used for lane arithmetic.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response and word-memory signals of the load/store unit.
// The LSU takes the slave modport; whoever drives the requests takes master.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              load_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall;
  logic              addr_err;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wd;
  logic              mem_we;
  logic [31:0]       mem_rd;

  modport slave (
    input  mem_read, mem_write, size, load_unsigned, addr, wdata, mem_rd,
    output rdata, stall, addr_err, mem_addr, mem_wd, mem_we
  );

  modport master (
    output mem_read, mem_write, size, load_unsigned, addr, wdata, mem_rd,
    input  rdata, stall, addr_err, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/load_store_unit_byte_lane_merge.sv
// Little-endian lane logic: builds the read-modify-write word for sub-word
// stores and extracts/extends the addressed lane(s) for loads.
module byte_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] memRd_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        loadUnsigned_i,
  output logic [31:0] merged_o,
  output logic [31:0] loadData_o
);

  logic [BYTE_W-1:0]   laneByte;
  logic [2*BYTE_W-1:0] laneHalf;
  logic                signFill;

  // Halfwords only ever sit in lane 0 or 2, so lane[1] picks the half.
  always_comb begin
    laneByte   = memRd_i[{lane_i, 3'b000} +: BYTE_W];
    laneHalf   = lane_i[1] ? memRd_i[31:16] : memRd_i[15:0];
    signFill   = 1'b0;
    merged_o   = memRd_i;
    loadData_o = memRd_i;
    case (size_i)
      SZ_BYTE: begin
        merged_o[{lane_i, 3'b000} +: BYTE_W] = wdata_i[7:0];
        signFill   = ~loadUnsigned_i & laneByte[BYTE_W-1];
        loadData_o = {{24{signFill}}, laneByte};
      end
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
        signFill   = ~loadUnsigned_i & laneHalf[2*BYTE_W-1];
        loadData_o = {{16{signFill}}, laneHalf};
      end
      default: begin
        merged_o   = wdata_i;
        loadData_o = memRd_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/halfword load-store front end for a word-only data memory. Loads are
// combinational; sub-word stores take a stalled read cycle then a write cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  load_store_unit_if.slave  bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] wordIdx_q, wordIdx_d;
  logic [31:0] merged_q, merged_d;

  logic [1:0]  lane;
  logic        isByte, isHalf, isWord;
  logic        misaligned, request, subWordStore;
  logic [31:0] wordIdx;
  logic [31:0] mergedWord, loadData;

  assign lane         = bus.addr[1:0];
  assign isByte       = (bus.size == SZ_BYTE);
  assign isHalf       = (bus.size == SZ_HALF);
  assign isWord       = ~isByte & ~isHalf;
  assign misaligned   = (isHalf & lane[0]) | (isWord & (lane != 2'b00));
  assign request      = bus.mem_read | bus.mem_write;
  assign subWordStore = bus.mem_write & ~misaligned & ~isWord;
  assign wordIdx      = 32'(bus.addr >> 2);

  byte_lane_merge u_laneMerge (
    .memRd_i        (bus.mem_rd),
    .wdata_i        (bus.wdata),
    .size_i         (bus.size),
    .lane_i         (lane),
    .loadUnsigned_i (bus.load_unsigned),
    .merged_o       (mergedWord),
    .loadData_o     (loadData)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wordIdx_q <= '0;
      merged_q  <= '0;
    end else begin
      state_q   <= state_d;
      wordIdx_q <= wordIdx_d;
      merged_q  <= merged_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wordIdx_d = wordIdx_q;
    merged_d  = merged_q;
    case (state_q)
      IDLE: begin
        if (subWordStore) begin
          state_d   = WRITE;
          wordIdx_d = wordIdx;
          merged_d  = mergedWord;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The held CPU request is ignored in WRITE; reset suppresses any write/stall.
  always_comb begin
    bus.rdata    = '0;
    bus.stall    = 1'b0;
    bus.addr_err = 1'b0;
    bus.mem_addr = wordIdx;
    bus.mem_wd   = bus.wdata;
    bus.mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (request && misaligned) begin
          bus.addr_err = 1'b1;
        end else begin
          if (bus.mem_read) bus.rdata = loadData;
          if (bus.mem_write) begin
            if (isWord) bus.mem_we = 1'b1;
            else        bus.stall  = 1'b1;
          end
        end
      end
      WRITE: begin
        bus.mem_addr = wordIdx_q;
        bus.mem_wd   = merged_q;
        bus.mem_we   = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      bus.mem_we = 1'b0;
      bus.stall  = 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model; inputs
// change on the falling edge and outputs are checked 1 time unit later.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:255];

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .MEM_WORDS(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  assign bus.mem_rd = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wd;
  end

  task automatic applyStimulus(input logic rstN, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset_n           = rstN;
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.size          = sz;
    bus.load_unsigned = uns;
    bus.addr          = a;
    bus.wdata         = wd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEAD_0001;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'h5566_7788;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b00;
    bus.load_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset held low, even with a sub-word store request present.
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'hAB);
    checkOutput("rst_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("rst_we", {31'b0, bus.mem_we}, 32'h0);

    // Idle, no request.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1234_5678);
    checkOutput("idle_rdata", bus.rdata, 32'h0);
    checkOutput("idle_wd", bus.mem_wd, 32'h1234_5678);
    checkOutput("idle_stall", {31'b0, bus.stall}, 32'h0);

    // sb 0x5 <- 0xAB over 0x11223344.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'hAB);
    checkOutput("sb_c0_stall", {31'b0, bus.stall}, 32'h1);
    checkOutput("sb_c0_we", {31'b0, bus.mem_we}, 32'h0);
    checkOutput("sb_c0_addr", bus.mem_addr, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'hAB);
    checkOutput("sb_c1_addr", bus.mem_addr, 32'h1);
    checkOutput("sb_c1_wd", bus.mem_wd, 32'h1122_AB44);
    checkOutput("sb_c1_we", {31'b0, bus.mem_we}, 32'h1);
    checkOutput("sb_c1_stall", {31'b0, bus.stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("sb_mem", mem[1], 32'h1122_AB44);
    checkOutput("sb_after_stall", {31'b0, bus.stall}, 32'h0);

    // Loads.
    mem[1] = 32'h8022_3344;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    checkOutput("lb_signed", bus.rdata, 32'hFFFF_FF80);
    checkOutput("lb_stall", {31'b0, bus.stall}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    checkOutput("lbu", bus.rdata, 32'h0000_0080);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    checkOutput("lb_lane0", bus.rdata, 32'h0000_0044);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    checkOutput("lh_signed", bus.rdata, 32'hFFFF_DEAD);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0);
    checkOutput("lhu_lane0", bus.rdata, 32'h0000_0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    checkOutput("lw", bus.rdata, 32'h8022_3344);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
    checkOutput("lw_reserved", bus.rdata, 32'h8022_3344);

    // sh 0x2 <- 0xBEEF over 0xDEAD0001.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF);
    checkOutput("sh_c0_stall", {31'b0, bus.stall}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF);
    checkOutput("sh_c1_addr", bus.mem_addr, 32'h0);
    checkOutput("sh_c1_wd", bus.mem_wd, 32'hBEEF_0001);
    checkOutput("sh_c1_we", {31'b0, bus.mem_we}, 32'h1);

    // sw 0x10, two back-to-back cycles, never stalls.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D);
    checkOutput("sw_addr", bus.mem_addr, 32'h4);
    checkOutput("sw_we", {31'b0, bus.mem_we}, 32'h1);
    checkOutput("sw_wd", bus.mem_wd, 32'hCAFE_F00D);
    checkOutput("sw_stall", {31'b0, bus.stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D);
    checkOutput("sw_c1_stall", {31'b0, bus.stall}, 32'h0);
    checkOutput("sw_mem", mem[4], 32'hCAFE_F00D);

    // Misaligned accesses.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    checkOutput("lh_mis_err", {31'b0, bus.addr_err}, 32'h1);
    checkOutput("lh_mis_rdata", bus.rdata, 32'h0);
    checkOutput("lh_mis_stall", {31'b0, bus.stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'h1111_2222);
    checkOutput("sw_mis_err", {31'b0, bus.addr_err}, 32'h1);
    checkOutput("sw_mis_we", {31'b0, bus.mem_we}, 32'h0);
    checkOutput("sw_mis_stall", {31'b0, bus.stall}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    checkOutput("aligned_no_err", {31'b0, bus.addr_err}, 32'h0);

    // Reset during the WRITE cycle of sb 0x8 <- 0x11.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h11);
    checkOutput("rstw_c0_stall", {31'b0, bus.stall}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h11);
    checkOutput("rstw_we", {31'b0, bus.mem_we}, 32'h0);
    checkOutput("rstw_stall", {31'b0, bus.stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h11);
    checkOutput("rstw_mem", mem[2], 32'h5566_7788);
    checkOutput("rstw_idle_stall", {31'b0, bus.stall}, 32'h1);
    checkOutput("rstw_idle_we", {31'b0, bus.mem_we}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h11);
    checkOutput("retry_wd", bus.mem_wd, 32'h5566_7711);
    checkOutput("retry_we", {31'b0, bus.mem_we}, 32'h1);

    // Read and write together: word write wins, rdata still from mem_rd.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0102_0304);
    checkOutput("rw_we", {31'b0, bus.mem_we}, 32'h1);
    checkOutput("rw_rdata", bus.rdata, 32'hBEEF_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("rw_mem", mem[0], 32'h0102_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
